// File: rtl/serial_bit_feeder_if.sv
// Handshake and serial-output bundle between a word producer and the serial bit feeder.
// The master side produces words; the slave side (the feeder) drives the serial stream.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load,
    input  ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  data_in, load,
    output ready, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: shifts WIDTH-bit words out one bit per clock, gapless
// across back-to-back words, with registered dout/dout_valid/busy/done.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic           clk,
  input logic           reset,
  serial_bit_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Accepting on the last-bit cycle is what keeps consecutive words gapless.
  assign ready  = (state_q == IDLE) | ((state_q == SHIFT) & (cnt_q == LAST));
  assign accept = bus.load & ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    dout_d       = IDLE_BIT;
    dout_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    if (accept) begin
      state_d      = SHIFT;
      cnt_d        = '0;
      shreg_d      = bus.data_in;
      dout_d       = head_bit(bus.data_in);
      dout_valid_d = 1'b1;
      busy_d       = 1'b1;
    end else if (state_q == SHIFT) begin
      if (cnt_q == LAST) begin
        state_d = IDLE;
      end else begin
        shreg_d      = shift_one(shreg_q);
        cnt_d        = cnt_q + CW'(1);
        dout_d       = head_bit(shreg_d);
        dout_valid_d = 1'b1;
        busy_d       = 1'b1;
        done_d       = (cnt_d == LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.ready      = ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench: two feeders (MSB-first/idle 0 and LSB-first/idle 1) share the same
// directed words; expected bit streams are queued at load time and popped by a monitor.
module tb_serial_bit_feeder;
  localparam int W = 6;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea_e, eb_e;
  int   nvec = 0;
  int   nbad = 0;

  always #5 clk = ~clk;

  serial_bit_feeder_if #(.WIDTH(W)) if_a ();
  serial_bit_feeder_if #(.WIDTH(W)) if_b ();

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] d);
    if_a.load    = ld;
    if_a.data_in = d;
    if_b.load    = ld;
    if_b.data_in = d;
  endtask

  // ea/eb are the expected dout sequences written left-to-right in time order.
  task automatic pushExp(input logic [W-1:0] ea, input logic [W-1:0] eb);
    for (int i = W - 1; i >= 0; i--) begin
      qa.push_back('{b: ea[i], last: (i == 0)});
      qb.push_back('{b: eb[i], last: (i == 0)});
    end
  endtask

  // Called at a negedge while the feeder is ready; returns at the negedge of the last bit.
  task automatic applyStimulus(input logic [W-1:0] w, input logic [W-1:0] ea,
                               input logic [W-1:0] eb, input bit intrude);
    checkOutput("A ready before load", if_a.ready, 1);
    checkOutput("B ready before load", if_b.ready, 1);
    drive(1'b1, w);
    pushExp(ea, eb);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (intrude && k == 2) drive(1'b1, 6'b111111);
      else drive(1'b0, W'($urandom));
      checkOutput("A dout_valid in word", if_a.dout_valid, 1);
      checkOutput("B dout_valid in word", if_b.dout_valid, 1);
      checkOutput("A ready in word", if_a.ready, (k == W));
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, W'($urandom));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (if_a.dout_valid) begin
      if (qa.size() == 0) checkOutput("A unexpected dout_valid", 1, 0);
      else begin
        ea_e = qa.pop_front();
        checkOutput("A dout", if_a.dout, ea_e.b);
        checkOutput("A done", if_a.done, ea_e.last);
        checkOutput("A busy", if_a.busy, 1);
      end
    end else begin
      checkOutput("A idle dout", if_a.dout, 0);
      checkOutput("A idle done", if_a.done, 0);
      checkOutput("A idle busy", if_a.busy, 0);
    end
    if (if_b.dout_valid) begin
      if (qb.size() == 0) checkOutput("B unexpected dout_valid", 1, 0);
      else begin
        eb_e = qb.pop_front();
        checkOutput("B dout", if_b.dout, eb_e.b);
        checkOutput("B done", if_b.done, eb_e.last);
        checkOutput("B busy", if_b.busy, 1);
      end
    end else begin
      checkOutput("B idle dout", if_b.dout, 1);
      checkOutput("B idle done", if_b.done, 0);
      checkOutput("B idle busy", if_b.busy, 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not complete, vectors=%0d", nvec);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    drive(1'b0, '0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("A ready in reset", if_a.ready, 1);
    checkOutput("A dout_valid in reset", if_a.dout_valid, 0);
    reset = 1'b0;
    idleCycles(3);

    $display("[TB] single word 001001");
    applyStimulus(6'b001001, 6'b001001, 6'b100100, 1'b0);
    idleCycles(3);

    $display("[TB] back-to-back 001001 then 011000");
    applyStimulus(6'b001001, 6'b001001, 6'b100100, 1'b0);
    applyStimulus(6'b011000, 6'b011000, 6'b000110, 1'b0);
    idleCycles(3);

    $display("[TB] load while busy is ignored");
    applyStimulus(6'b001001, 6'b001001, 6'b100100, 1'b1);
    idleCycles(2);

    $display("[TB] reset during bit 3");
    checkOutput("A ready before load", if_a.ready, 1);
    drive(1'b1, 6'b001001);
    pushExp(6'b001001, 6'b100100);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(1'b0, W'($urandom));
      checkOutput("A ready mid-word", if_a.ready, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("A ready after reset", if_a.ready, 1);
    checkOutput("A dout_valid after reset", if_a.dout_valid, 0);
    checkOutput("B dout after reset", if_b.dout, 1);
    checkOutput("A busy after reset", if_a.busy, 0);
    qa.delete();
    qb.delete();
    reset = 1'b0;
    idleCycles(2);
    applyStimulus(6'b010010, 6'b010010, 6'b010010, 1'b0);
    idleCycles(3);

    $display("[TB] further words, gapless");
    applyStimulus(6'b100100, 6'b100100, 6'b001001, 1'b0);
    applyStimulus(6'b110101, 6'b110101, 6'b101011, 1'b0);
    idleCycles(4);

    checkOutput("A queue drained", qa.size(), 0);
    checkOutput("B queue drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
